btn_conditioner: RTL
====================

// Module: btn_conditioner
// PURPOSE
//  Conditions the four raw Simon pushbuttons ahead of the simon game core. Per channel:
//  synchroniser, time-based debounce, then edge detection.
//  Outputs debounced levels, which drive the core's btn bus.
//  Also outputs a one-deep, handshaked press-event register, so the core (or a test
//  harness) consumes each press exactly once.
//  Clocked by the 25 MHz divided clock (CLKD at top level).
// PARAMETERS
//  N_BTN            4      number of button channels (btn_code width = $clog2(N_BTN))
//  TICKS_PER_MILLI  25000  clock cycles per millisecond
//  DEBOUNCE_MS      10     time input must be stable before level changes
//  SYNC_STAGES      2      synchroniser flops per channel (>=2)
// PORTS
//  CLK          in   1               system clock (25 MHz)
//  RST          in   1               synchronous reset, active-high
//  btn_raw      in   N_BTN           raw pushbuttons, active-high, asynchronous
//  btn_level    out  N_BTN           debounced level, 1 = pressed
//  btn_press    out  N_BTN           1-cycle pulse on debounced 0->1
//  btn_release  out  N_BTN           1-cycle pulse on debounced 1->0
//  ev_valid     out  1               press event pending
//  ev_code      out  $clog2(N_BTN)   index of pending press, stable while ev_valid
//  ev_ready     in   1               consumer accepts event (valid&ready = consumed)
//  ev_overflow  out  1               sticky: press lost (event full or simultaneous)
// BEHAVIOUR
//  Interface: one clock, CLK; reset is synchronous and active-high on RST. All state
//    updates on posedge CLK.
//  Reset: sync flops, stable levels, counters, btn_level, btn_press, btn_release,
//    ev_valid, ev_code and ev_overflow all go to 0.
//  RST has priority over every other event in the same cycle.
//  THRESH = TICKS_PER_MILLI*DEBOUNCE_MS. Counter width = $clog2(THRESH+1).
//  Per channel, s = synchronised input, L = stable level:
//   - s == L: counter cleared to 0.
//   - s != L: counter increments. When it would reach THRESH, then L <= s and counter <= 0.
//   - Any glitch back to L before THRESH clears the counter (no partial credit).
//  Latency: a clean raw edge changes btn_level exactly SYNC_STAGES+THRESH cycles later.
//  btn_press / btn_release are asserted in the same cycle btn_level changes, for one cycle.
//  A button held through reset release gives a press after SYNC_STAGES+THRESH cycles.
//  Event register (valid/ready, registered output):
//   - Load: when any btn_press bit is set and the register is free, ev_valid <= 1 and
//     ev_code <= lowest set index. "Free" means !ev_valid, or ev_valid&ev_ready in the
//     same cycle (back-to-back accepted).
//   - Other press bits set in the same cycle are dropped, and ev_overflow <= 1.
//   - Press while full and not being consumed: dropped, ev_overflow <= 1, ev_code unchanged.
//   - Consume: ev_valid & ev_ready with no new press -> ev_valid <= 0 next cycle.
//   - ev_ready while !ev_valid: ignored.
//   - ev_overflow clears only on RST.
//  Releases never generate events.
// STRUCTURE
//  Shared include simon_defs.vh holds N_BTN, TICKS_PER_MILLI, DEBOUNCE_MS and BTN_W.
//  simon top and pixel_gen use the same definitions.
//  Sub-module btn_debounce_ch: one channel, covering synchroniser, counter, stable
//    level and edge pulses. It is instantiated N_BTN times in a generate loop.
//  Priority encoder and event register live in btn_conditioner itself.
// TESTING (bench params: TICKS_PER_MILLI=10, DEBOUNCE_MS=2 -> THRESH=20, SYNC_STAGES=2)
//  1. Clean press: btn_raw[2] 0->1 at cycle 0, held.
//     -> btn_level[2]=1 and btn_press[2]=1 at cycle 22 only. ev_valid=1, ev_code=2 at cycle 23.
//  2. Bounce: btn_raw[0] toggles every 5 cycles for 40 cycles, then held high.
//     -> no btn_press during the bounce. Press occurs 22 cycles after the last edge.
//  3. Simultaneous: btn_raw[1] and btn_raw[3] rise in the same cycle.
//     -> ev_code=1, ev_overflow=1, btn_level=4'b1010.
//  4. Full: press btn 0 and leave it unconsumed (ev_ready=0), then press btn 3.
//     -> ev_code stays 0, ev_overflow=1.
//     Then ev_ready=1 for 1 cycle -> ev_valid=0.
//  5. Back-to-back: ev_ready held 1, presses on btn 1 then btn 2 landing on adjacent cycles.
//     -> two events (codes 1, 2), ev_overflow=0.
//  6. Reset mid-count: RST for 1 cycle at count 15 of a btn_raw[3] press, raw still high.
//     -> all outputs 0 the next cycle. Press recurs 22 cycles after RST deasserts.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// Shared button-conditioning definitions for the Simon design.
// Holds default channel count, timing constants and the debounce threshold helper.
package btn_conditioner_pkg;

    localparam int unsigned DefNBtn          = 4;
    localparam int unsigned DefBtnW          = $clog2(DefNBtn);
    localparam int unsigned DefTicksPerMilli = 25000;
    localparam int unsigned DefDebounceMs    = 10;
    localparam int unsigned DefSyncStages    = 2;

    function automatic int unsigned debounce_thresh(input int unsigned ticks_per_milli,
                                                    input int unsigned debounce_ms);
        return ticks_per_milli * debounce_ms;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, time-based debounce counter, stable level
// and registered one-cycle press/release pulses aligned with the level change.
module btn_debounce_ch
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned THRESH      = 20,
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CntW = $clog2(THRESH + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, release_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any return to the stable level wipes the count: no partial credit for glitches.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s != level_q) begin
            if (cnt_q == CntW'(THRESH - 1)) begin
                level_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw Simon pushbuttons: per-channel debounce plus a one-deep
// valid/ready press-event register with a sticky overflow flag.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN           = DefNBtn,
    parameter int unsigned TICKS_PER_MILLI = DefTicksPerMilli,
    parameter int unsigned DEBOUNCE_MS     = DefDebounceMs,
    parameter int unsigned SYNC_STAGES     = DefSyncStages
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         btn_level,
    output logic [N_BTN-1:0]         btn_press,
    output logic [N_BTN-1:0]         btn_release,
    output logic                     ev_valid,
    output logic [$clog2(N_BTN)-1:0] ev_code,
    input  logic                     ev_ready,
    output logic                     ev_overflow
);

    localparam int unsigned BtnW   = $clog2(N_BTN);
    localparam int unsigned Thresh = debounce_thresh(TICKS_PER_MILLI, DEBOUNCE_MS);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .THRESH      (Thresh),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .raw_i     (btn_raw[g]),
            .level_o   (btn_level[g]),
            .press_o   (btn_press[g]),
            .release_o (btn_release[g])
        );
    end

    logic            valid_q, valid_d;
    logic [BtnW-1:0] code_q, code_d;
    logic            ovf_q, ovf_d;
    logic [BtnW-1:0] low_idx;
    logic            multi;

    always_comb begin
        low_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                low_idx = BtnW'(i);
            end
        end
    end

    assign multi = |(btn_press & (btn_press - N_BTN'(1)));

    // A press may load in the same cycle the pending event is consumed.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q;
        if (|btn_press) begin
            if (!valid_q || ev_ready) begin
                valid_d = 1'b1;
                code_d  = low_idx;
                if (multi) begin
                    ovf_d = 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end else if (ev_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ev_valid    = valid_q;
    assign ev_code     = code_q;
    assign ev_overflow = ovf_q;

endmodule
